// File: rtl/pll_seq_pkg.sv
// Shared definitions for the GPU pixel-clock PLL sequencer: state
// encoding, status widths and the default timing constants.
package pll_seq_pkg;

    // Sequencer states. HOLD is the reset/power-up state.
    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    // Width of the retry counter; holds MAX_RETRIES up to 15.
    localparam int RETRY_W = 4;

    // Default timing for a 16 MHz board clock.
    localparam int DEF_RESET_CYCLES  = 16;     // RESETB low time per attempt
    localparam int DEF_LOCK_TIMEOUT  = 65536;  // ~4 ms lock window
    localparam int DEF_STABLE_CYCLES = 1024;   // continuous lock before release
    localparam int DEF_MAX_RETRIES   = 3;      // retries after the first attempt

    // Largest of three cycle counts; sizes the shared state counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_sequencer_sync2.sv
// Generic two-flop synchronizer with synchronous reset. Each bit is an
// independent asynchronous status input; no bus coherency is implied.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        // First stage may go metastable; second stage gives it a full cycle to settle.
        always_ff @(posedge i_clk) begin
            if (i_srst) begin
                r_meta[gi] <= 1'b0;
                r_sync[gi] <= 1'b0;
            end else begin
                r_meta[gi] <= i_d[gi];
                r_sync[gi] <= r_meta[gi];
            end
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_sequencer.sv
// Power-up and recovery sequencer for the GPU pixel-clock PLL.
// Holds the PLL in reset, waits for a clean lock, requires the lock to
// stay up for a stable window, then releases the GPU domain reset.
// Failed lock attempts are retried; exhausted retries park the PLL in
// reset and raise fault. Loss of lock in RUN re-sequences from HOLD.
module pll_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pll_locked,
    input  logic               i_restart,
    input  logic               i_clear_status,
    output logic               o_pll_resetb,
    output logic               o_domain_rst,
    output logic               o_ready,
    output logic               o_lock_lost,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic               o_fault
);

    // One counter serves every timed state, so it is sized for the longest.
    localparam int CNT_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);

    // Synchronized lock indication.
    logic w_lock_s;

    // Registered state.
    pll_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic               r_lock_lost;
    logic               r_pll_resetb;
    logic               r_domain_rst;
    logic               r_ready;
    logic               r_fault;

    // Next-state decode.
    pll_state_t         w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [RETRY_W-1:0] w_retry_next;
    logic               w_lost_set;
    logic               w_lock_lost_next;
    logic               w_pll_resetb_next;
    logic               w_domain_rst_next;
    logic               w_ready_next;
    logic               w_fault_next;

    // pll_locked is asynchronous to the board clock.
    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk  (i_clk),
        .i_srst (i_rst),
        .i_d    (i_pll_locked),
        .o_q    (w_lock_s)
    );

    // Transition decode; restart overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        w_retry_next = r_retry_cnt;
        w_lost_set   = 1'b0;

        if (i_restart) begin
            w_state_next = HOLD;
            w_retry_next = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == RESET_LAST) begin
                        w_state_next = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_next = STABLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        // Retry count saturates: it only advances below the limit.
                        if (r_retry_cnt >= RETRY_MAX) begin
                            w_state_next = FAULT;
                        end else begin
                            w_retry_next = r_retry_cnt + RETRY_ONE;
                            w_state_next = HOLD;
                        end
                    end
                end
                STABLE: begin
                    // A dropout restarts the lock wait without consuming a retry.
                    if (!w_lock_s) begin
                        w_state_next = WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        w_state_next = HOLD;
                        w_retry_next = '0;
                        w_lost_set   = 1'b1;
                    end
                end
                FAULT: begin
                    // Parked until restart or rst.
                    w_state_next = FAULT;
                end
                default: begin
                    w_state_next = HOLD;
                    w_retry_next = '0;
                end
            endcase
        end
    end

    // Shared counter: clears on any state change or restart, runs only in timed states.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_restart || (w_state_next != r_state)) begin
            w_cnt_next = '0;
        end else if ((r_state == HOLD) || (r_state == WAIT_LOCK) || (r_state == STABLE)) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // Sticky lock_lost: a set in the same cycle as a clear wins.
    always_comb begin
        w_lock_lost_next = r_lock_lost;
        if (w_lost_set) begin
            w_lock_lost_next = 1'b1;
        end else if (i_clear_status) begin
            w_lock_lost_next = 1'b0;
        end
    end

    // Outputs decoded from the next state so they change on the same edge as the state.
    always_comb begin
        w_pll_resetb_next = 1'b1;
        w_domain_rst_next = 1'b1;
        w_ready_next      = 1'b0;
        w_fault_next      = 1'b0;
        case (w_state_next)
            HOLD: begin
                w_pll_resetb_next = 1'b0;
            end
            RUN: begin
                w_domain_rst_next = 1'b0;
                w_ready_next      = 1'b1;
            end
            FAULT: begin
                w_pll_resetb_next = 1'b0;
                w_fault_next      = 1'b1;
            end
            default: begin
                w_pll_resetb_next = 1'b1;
            end
        endcase
    end

    // State, counters and status flops; rst restores every value at once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= HOLD;
            r_cnt        <= '0;
            r_retry_cnt  <= '0;
            r_lock_lost  <= 1'b0;
            r_pll_resetb <= 1'b0;
            r_domain_rst <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_retry_cnt  <= w_retry_next;
            r_lock_lost  <= w_lock_lost_next;
            r_pll_resetb <= w_pll_resetb_next;
            r_domain_rst <= w_domain_rst_next;
            r_ready      <= w_ready_next;
            r_fault      <= w_fault_next;
        end
    end

    assign o_pll_resetb = r_pll_resetb;
    assign o_domain_rst = r_domain_rst;
    assign o_ready      = r_ready;
    assign o_lock_lost  = r_lock_lost;
    assign o_retry_cnt  = r_retry_cnt;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_pll_sequencer.sv
// Testbench for pll_sequencer with short timing:
// RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
// Each vector holds inputs for a number of clock edges, then compares
// {pll_resetb, domain_rst, ready, lock_lost, fault, retry_cnt[3:0]}.
module tb_pll_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       restart;
    logic       clear_status;
    logic       pll_resetb;
    logic       domain_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic       fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cycles;
        logic       in_rst;
        logic       in_locked;
        logic       in_restart;
        logic       in_clear;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    pll_sequencer #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pll_locked   (pll_locked),
        .i_restart      (restart),
        .i_clear_status (clear_status),
        .o_pll_resetb   (pll_resetb),
        .o_domain_rst   (domain_rst),
        .o_ready        (ready),
        .o_lock_lost    (lock_lost),
        .o_retry_cnt    (retry_cnt),
        .o_fault        (fault)
    );

    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic add(input int cyc, input logic r, l, rs, cl,
                       input logic rb, dr, rd, ll, ft, input logic [3:0] rt);
        vec_t v;
        v.cycles     = cyc;
        v.in_rst     = r;
        v.in_locked  = l;
        v.in_restart = rs;
        v.in_clear   = cl;
        v.exp        = {rb, dr, rd, ll, ft, rt};
        vecs.push_back(v);
    endtask

    function automatic logic [8:0] outs();
        return {pll_resetb, domain_rst, ready, lock_lost, fault, retry_cnt};
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end else begin
            $display("%s: got %0d ok", name, act);
        end
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        pll_locked   = 1'b0;
        restart      = 1'b0;
        clear_status = 1'b0;

        //   cyc rst lk rs cl | rb dr rd ll ft retry
        // Power-up: 4-cycle RESETB pulse, lock 6 cycles after rst, ready 11 edges later.
        add( 2, 1,0,0,0, 0,1,0,0,0, 0);   // 0  reset values
        add( 3, 0,0,0,0, 0,1,0,0,0, 0);   // 1  HOLD cnt3
        add( 1, 0,0,0,0, 1,1,0,0,0, 0);   // 2  WAIT_LOCK
        add( 2, 0,0,0,0, 1,1,0,0,0, 0);   // 3  WAIT cnt2
        add(10, 0,1,0,0, 1,1,0,0,0, 0);   // 4  sync + STABLE cnt7
        add( 1, 0,1,0,0, 1,0,1,0,0, 0);   // 5  RUN on 11th edge
        // Lock loss in RUN, then clear_status.
        add( 2, 0,0,0,0, 1,0,1,0,0, 0);   // 6  still RUN during sync lag
        add( 1, 0,0,0,0, 0,1,0,1,0, 0);   // 7  3rd edge: HOLD, lock_lost
        add( 3, 0,0,0,0, 0,1,0,1,0, 0);   // 8  HOLD cnt3
        add( 1, 0,0,0,0, 1,1,0,1,0, 0);   // 9  WAIT_LOCK
        add( 1, 0,0,0,1, 1,1,0,0,0, 0);   // 10 clear_status
        // Glitch during STABLE.
        add( 3, 0,1,0,0, 1,1,0,0,0, 0);   // 11 STABLE cnt0
        add( 5, 0,1,0,0, 1,1,0,0,0, 0);   // 12 STABLE cnt5
        add( 1, 0,0,0,0, 1,1,0,0,0, 0);   // 13 one-cycle dropout
        add( 1, 0,1,0,0, 1,1,0,0,0, 0);   // 14 STABLE cnt7, must not release
        add( 1, 0,1,0,0, 1,1,0,0,0, 0);   // 15 back to WAIT_LOCK
        add( 8, 0,1,0,0, 1,1,0,0,0, 0);   // 16 full STABLE again, cnt7
        add( 1, 0,1,0,0, 1,0,1,0,0, 0);   // 17 RUN, retry_cnt still 0
        // Loss with simultaneous clear: set wins.
        add( 2, 0,0,0,0, 1,0,1,0,0, 0);   // 18 RUN during sync lag
        add( 1, 0,0,0,1, 0,1,0,1,0, 0);   // 19 HOLD, lock_lost stays 1
        // Never locks: three attempts, then FAULT.
        add( 3, 0,0,0,0, 0,1,0,1,0, 0);   // 20 HOLD cnt3
        add( 1, 0,0,0,0, 1,1,0,1,0, 0);   // 21 WAIT cnt0
        add(31, 0,0,0,0, 1,1,0,1,0, 0);   // 22 WAIT cnt31
        add( 1, 0,0,0,0, 0,1,0,1,0, 1);   // 23 retry 1
        add( 3, 0,0,0,0, 0,1,0,1,0, 1);   // 24 HOLD cnt3
        add( 1, 0,0,0,0, 1,1,0,1,0, 1);   // 25 WAIT cnt0
        add(31, 0,0,0,0, 1,1,0,1,0, 1);   // 26 WAIT cnt31
        add( 1, 0,0,0,0, 0,1,0,1,0, 2);   // 27 retry 2
        add( 4, 0,0,0,0, 1,1,0,1,0, 2);   // 28 WAIT cnt0
        add(31, 0,0,0,0, 1,1,0,1,0, 2);   // 29 WAIT cnt31
        add( 1, 0,0,0,0, 0,1,0,1,1, 2);   // 30 FAULT
        add(20, 0,0,0,0, 0,1,0,1,1, 2);   // 31 parked
        add( 5, 0,1,0,0, 0,1,0,1,1, 2);   // 32 late lock ignored
        // restart from FAULT, then from RUN.
        add( 1, 0,1,1,0, 0,1,0,1,0, 0);   // 33 HOLD, fault cleared
        add( 3, 0,1,0,0, 0,1,0,1,0, 0);   // 34 HOLD cnt3
        add( 1, 0,1,0,0, 1,1,0,1,0, 0);   // 35 WAIT
        add( 1, 0,1,0,0, 1,1,0,1,0, 0);   // 36 STABLE cnt0
        add( 7, 0,1,0,0, 1,1,0,1,0, 0);   // 37 STABLE cnt7
        add( 1, 0,1,0,0, 1,0,1,1,0, 0);   // 38 RUN
        add( 1, 0,1,1,0, 0,1,0,1,0, 0);   // 39 restart in RUN
        // rst mid-STABLE, then a normal power-up.
        add( 3, 0,1,0,0, 0,1,0,1,0, 0);   // 40 HOLD cnt3
        add( 1, 0,1,0,0, 1,1,0,1,0, 0);   // 41 WAIT
        add( 1, 0,1,0,0, 1,1,0,1,0, 0);   // 42 STABLE cnt0
        add( 5, 0,1,0,0, 1,1,0,1,0, 0);   // 43 STABLE cnt5
        add( 1, 1,1,0,0, 0,1,0,0,0, 0);   // 44 rst: all reset values
        add( 3, 0,1,0,0, 0,1,0,0,0, 0);   // 45 HOLD cnt3
        add( 1, 0,1,0,0, 1,1,0,0,0, 0);   // 46 WAIT
        add( 1, 0,1,0,0, 1,1,0,0,0, 0);   // 47 STABLE cnt0
        add( 7, 0,1,0,0, 1,1,0,0,0, 0);   // 48 STABLE cnt7
        add( 1, 0,1,0,0, 1,0,1,0,0, 0);   // 49 RUN

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].in_rst;
            pll_locked   = vecs[i].in_locked;
            restart      = vecs[i].in_restart;
            clear_status = vecs[i].in_clear;
            repeat (vecs[i].cycles) @(posedge clk);
            @(negedge clk);
            checks++;
            if (outs() !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d: got %b required %b (rb dr rd ll ft retry)",
                         i, outs(), vecs[i].exp);
            end else begin
                $display("vec%0d: outputs %b ok", i, outs());
            end
        end
        restart      = 1'b0;
        clear_status = 1'b0;
        rst          = 1'b0;

        // Edges from pll_locked falling in RUN to domain_rst rising.
        pll_locked = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (domain_rst) break;
        end
        check_int("loss_to_domain_rst_edges", n, 3);
        check_int("loss_sets_lock_lost", int'(lock_lost), 1);

        // Cycles pll_resetb stays low for this HOLD entry (current cycle counts).
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (pll_resetb) break;
            n++;
        end
        check_int("resetb_low_cycles", n, 4);

        // Edges from pll_locked rising to ready.
        pll_locked = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (ready) break;
        end
        check_int("lock_to_ready_edges", n, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
